max_stream: RTL and testbench

Sequential successor of the combinational two-operand `MAX` block. It scans a frame of 1..N_MAX samples of W bits, delivered one per handshake. For each frame it returns the maximum value and the position of its first occurrence. It sits between a sample producer (valid/ready) and a consumer (valid/ack). The comparison is unsigned or two's-complement signed, selected per frame.

---
 rtl/max_stream_pkg.sv | 20 ++
 rtl/max_cmp.sv | 19 +
 rtl/max_stream.sv | 106 ++++++++++
 tb/tb_max_stream.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_stream_pkg.sv
// Shared FSM encoding and the width helper used by max_stream and its comparator.
package max_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Constant-evaluable ceil(log2(v)); returns 0 for v <= 1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Combinational a > b on W-bit operands, unsigned or two's-complement by sgn.
// Both operands are widened to W+1 bits so one signed compare covers both modes.
module max_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sgn,
  output logic         a_gt_b
);

  logic [W:0] a_x;
  logic [W:0] b_x;

  assign a_x    = {sgn & a[W-1], a};
  assign b_x    = {sgn & b[W-1], b};
  assign a_gt_b = $signed(a_x) > $signed(b_x);

endmodule

// File: rtl/max_stream.sv
// Frame max/first-index scanner: one sample per cycle, result valid the cycle after the last accept.
// in_ready/out_valid/busy decode registered state only; the result is held until out_ack.
module max_stream
  import max_stream_pkg::*;
#(
  parameter int  W     = 8,
  parameter int  N_MAX = 16,
  localparam int LW    = clog2_f(N_MAX + 1),
  localparam int IW    = clog2_f(N_MAX)
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          sgn,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_max,
  output logic [IW-1:0] out_idx,
  input  logic          out_ack,
  output logic          busy
);

  localparam logic [LW-1:0] LEN_MAX = LW'(N_MAX);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q,   cnt_d;
  logic [LW-1:0] len_q,   len_d;
  logic          sgn_q,   sgn_d;
  logic [W-1:0]  max_q,   max_d;
  logic [IW-1:0] idx_q,   idx_d;

  logic gt;
  logic last;

  max_cmp #(.W(W)) u_cmp (
    .a      (in_data),
    .b      (max_q),
    .sgn    (sgn_q),
    .a_gt_b (gt)
  );

  assign last = (LW'(cnt_q) == (len_q - LW'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    max_d   = max_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          len_d   = (len > LEN_MAX) ? LEN_MAX : len;
          sgn_d   = sgn;
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          // Strict compare: a tie never displaces the earlier index.
          if ((cnt_q == '0) || gt) begin
            max_d = in_data;
            idx_d = cnt_q;
          end
          // cnt holds on the last accept so it never reaches N_MAX.
          if (last) state_d = DONE;
          else      cnt_d   = cnt_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sgn_q   <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sgn_q   <= sgn_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_max   = max_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_max_stream.sv
// Randomised and directed checks of max_stream against a value-level max/first-index model.
module tb_max_stream;

  localparam int W     = 8;
  localparam int N_MAX = 16;
  localparam int LW    = 5;
  localparam int IW    = 4;

  logic          clock;
  logic          reset_;
  logic          start;
  logic [LW-1:0] len;
  logic          sgn;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic          out_ack;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] frame_q[$];

  max_stream #(.W(W), .N_MAX(N_MAX)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .start     (start),
    .len       (len),
    .sgn       (sgn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_ack   (out_ack),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Value of a sample as a plain integer under the chosen interpretation.
  function automatic int val(input logic [W-1:0] d, input logic s);
    logic signed [W-1:0] t;
    t = d;
    if (s) return int'(t);
    return int'({1'b0, d});
  endfunction

  // Largest value over the first n samples, first position where it occurs.
  function automatic void model(input int n, input logic s, output logic [W-1:0] mx, output int ix);
    int best;
    best = val(frame_q[0], s);
    ix   = 0;
    for (int i = 1; i < n; i++) begin
      if (val(frame_q[i], s) > best) begin
        best = val(frame_q[i], s);
        ix   = i;
      end
    end
    mx = frame_q[ix];
  endfunction

  task automatic start_frame(input int l, input logic s);
    start = 1'b1;
    len   = LW'(l);
    sgn   = s;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Drives frame_q; reports cycles where in_ready was low while it should be high
  // and samples driven while out_valid was already up.
  task automatic feed(input int gap_at, input int gap_len, input int gap_prob,
                      output int bad_rdy, output int early);
    bad_rdy = 0;
    early   = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          if (!in_ready) bad_rdy++;
          @(negedge clock);
        end
      end
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 99) < gap_prob) begin
          in_valid = 1'b0;
          @(negedge clock);
        end
      end
      if (out_valid) early++;
      in_valid = 1'b1;
      in_data  = frame_q[i];
      for (int k = 0; k < 20 && !in_ready; k++) begin
        bad_rdy++;
        @(negedge clock);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic ack;
    out_ack = 1'b1;
    @(negedge clock);
    out_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset_ = 1'b0; start = 0; len = 0; sgn = 0; in_valid = 0; in_data = 0; out_ack = 0;
    #3;
    checks++; if ({in_ready, out_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {in_ready, out_valid, busy}); end
    checks++; if (out_max !== 8'd0 || out_idx !== 4'd0) begin errors++; $display("FAIL reset_result got max=%0d idx=%0d want 0 0", out_max, out_idx); end
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_unsigned;
    int br, ea;
    frame_q = '{8'd15, 8'd200, 8'd12};
    start_frame(3, 1'b0);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL uns_collect rdy=%b busy=%b want 1 1", in_ready, busy); end
    feed(-1, 0, 0, br, ea);
    checks++; if (br != 0 || ea != 0) begin errors++; $display("FAIL uns_flow bad_rdy=%0d early=%0d want 0 0", br, ea); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uns_latency out_valid got %b want 1", out_valid); end
    checks++; if (out_max !== 8'd200 || out_idx !== 4'd1) begin errors++; $display("FAIL uns_result got %0d/%0d want 200/1", out_max, out_idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL uns_done_rdy got %b want 0", in_ready); end
    ack();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL uns_ack vld=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_signed;
    int br, ea;
    frame_q = '{8'd15, 8'd200, 8'd12};
    start_frame(3, 1'b1);
    feed(-1, 0, 0, br, ea);
    checks++; if (out_valid !== 1'b1 || br != 0 || ea != 0) begin errors++; $display("FAIL sgn_flow vld=%b bad_rdy=%0d early=%0d want 1 0 0", out_valid, br, ea); end
    checks++; if (out_max !== 8'd15 || out_idx !== 4'd0) begin errors++; $display("FAIL sgn_result got %0d/%0d want 15/0", out_max, out_idx); end
    ack();
  endtask

  task automatic test_ties_backpressure;
    int br, ea;
    frame_q = '{8'd7, 8'd9, 8'd9, 8'd3};
    start_frame(4, 1'b0);
    feed(2, 2, 0, br, ea);
    checks++; if (br != 0) begin errors++; $display("FAIL tie_gap_ready low cycles got %0d want 0", br); end
    checks++; if (ea != 0 || out_valid !== 1'b1) begin errors++; $display("FAIL tie_count early=%0d vld=%b want 0 1", ea, out_valid); end
    checks++; if (out_max !== 8'd9 || out_idx !== 4'd1) begin errors++; $display("FAIL tie_result got %0d/%0d want 9/1", out_max, out_idx); end
    ack();
  endtask

  task automatic test_len_edges;
    int br, ea, acc;
    logic [W-1:0] emx;
    int eix;
    start_frame(0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b want 0", busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL len0_idle busy=%b rdy=%b want 0 0", busy, in_ready); end

    frame_q = {};
    for (int i = 0; i < 20; i++) frame_q.push_back(W'($urandom));
    start_frame(20, 1'b0);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = frame_q[i];
      if (in_ready) acc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    model(16, 1'b0, emx, eix);
    checks++; if (acc != 16) begin errors++; $display("FAIL clamp_accepts got %0d want 16", acc); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clamp_done out_valid got %b want 1", out_valid); end
    checks++; if (out_max !== emx || int'(out_idx) != eix) begin errors++; $display("FAIL clamp_result got %0d/%0d want %0d/%0d", out_max, out_idx, emx, eix); end
    ack();

    frame_q = '{8'h80};
    start_frame(1, 1'b0);
    feed(-1, 0, 0, br, ea);
    checks++; if (out_valid !== 1'b1 || out_max !== 8'd128 || out_idx !== 4'd0) begin errors++; $display("FAIL len1 got vld=%b %0d/%0d want 1 128/0", out_valid, out_max, out_idx); end
    ack();
  endtask

  task automatic test_hold;
    int br, ea, bad;
    frame_q = '{8'd3, 8'd4};
    start_frame(2, 1'b0);
    feed(-1, 0, 0, br, ea);
    bad = 0;
    start = 1'b1;
    len   = LW'(3);
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || out_max !== 8'd4 || out_idx !== 4'd1 || busy !== 1'b1) bad++;
      @(negedge clock);
    end
    start = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable bad cycles got %0d want 0", bad); end
    ack();
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midframe;
    int br, ea;
    frame_q = '{8'd50, 8'd60};
    start_frame(4, 1'b0);
    feed(-1, 0, 0, br, ea);
    #2 reset_ = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, busy} !== 3'b000 || out_max !== 8'd0 || out_idx !== 4'd0)
      begin errors++; $display("FAIL midreset got rdy=%b vld=%b busy=%b max=%0d idx=%0d want all 0", in_ready, out_valid, busy, out_max, out_idx); end
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    frame_q = '{8'd10, 8'd30};
    start_frame(2, 1'b0);
    feed(-1, 0, 0, br, ea);
    checks++; if (out_valid !== 1'b1 || out_max !== 8'd30 || out_idx !== 4'd1) begin errors++; $display("FAIL post_reset got vld=%b %0d/%0d want 1 30/1", out_valid, out_max, out_idx); end
    ack();
  endtask

  task automatic test_random;
    int br, ea, n, eix;
    logic s;
    logic [W-1:0] emx;
    for (int f = 0; f < 32; f++) begin
      n = $urandom_range(1, N_MAX);
      s = 1'($urandom_range(0, 1));
      frame_q = {};
      // Narrow value range some of the time so ties actually occur.
      for (int i = 0; i < n; i++)
        frame_q.push_back((f % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 3) + 8'd126));
      model(n, s, emx, eix);
      start_frame(n, s);
      feed(-1, 0, 25, br, ea);
      checks++; if (out_valid !== 1'b1 || br != 0 || ea != 0) begin errors++; $display("FAIL rand%0d_flow vld=%b bad_rdy=%0d early=%0d want 1 0 0", f, out_valid, br, ea); end
      checks++; if (out_max !== emx || int'(out_idx) != eix) begin errors++; $display("FAIL rand%0d_result len=%0d sgn=%0d got %0d/%0d want %0d/%0d", f, n, s, out_max, out_idx, emx, eix); end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_ties_backpressure();
    test_len_edges();
    test_hold();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
